// File: rtl/spi_ctrl_writer_pkg.sv
// Shared types and helpers for the SPI register-write controller.
// Frames are {write bit, address, data}, sent MSB first.
package spi_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int FRAME_W    = 1 + ADDR_W_DEF + DATA_W_DEF;
  localparam logic WRITE_BIT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  // The caller zero-extends addr/data; the result is truncated to the real frame width.
  function automatic logic [31:0] pack_frame(input logic [31:0] addr,
                                             input logic [31:0] data,
                                             input int          addr_w,
                                             input int          data_w);
    logic [31:0] f;
    f = {31'd0, WRITE_BIT} << (addr_w + data_w);
    f = f | (addr << data_w) | data;
    return f;
  endfunction

endpackage

// File: rtl/spi_ctrl_writer_if.sv
// Command handshake plus SPI pins of the register-write controller.
// master = command issuer, slave = the controller itself.
interface spi_ctrl_writer_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              busy;
  logic              done;
  logic              spi_ncs;
  logic              spi_sclk;
  logic              spi_copi;

  modport master (
    output cmd_valid, cmd_addr, cmd_data,
    input  cmd_ready, busy, done, spi_ncs, spi_sclk, spi_copi
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data,
    output cmd_ready, busy, done, spi_ncs, spi_sclk, spi_copi
  );
endinterface

// File: rtl/spi_ctrl_writer_clk_div.sv
// SCLK half-period divider: strobes half_tick every CLK_DIV enabled cycles.
// clr is synchronous so the FSM restarts a fresh half-period on entry to SHIFT.
module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic half_tick
);
  localparam int CNT_W = $clog2(CLK_DIV) + 1;

  logic [CNT_W-1:0] cnt;

  assign half_tick = en && (cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (half_tick) cnt <= '0;
      else           cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_ctrl_writer.sv
// SPI mode-0 initiator that serialises register-write commands as
// {1, addr, data} frames on nCS/SCLK/COPI; every output is a flop.
module spi_ctrl_writer
  import spi_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input logic               clk,
  input logic               rst,
  spi_ctrl_writer_if.slave  bus
);
  localparam int FRAME_LEN = 1 + ADDR_W + DATA_W;
  localparam int BIT_W     = $clog2(FRAME_LEN);
  localparam int PH_W      = $clog2(CS_SETUP + CS_HOLD + CS_GAP + 1);

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [FRAME_LEN-1:0] frame_next;
  logic [PH_W-1:0]      ph_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 half_tick;
  logic                 accept;

  assign frame_next = FRAME_LEN'(pack_frame(32'(bus.cmd_addr), 32'(bus.cmd_data), ADDR_W, DATA_W));
  assign accept     = bus.cmd_valid && bus.cmd_ready;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .en        (state == SHIFT),
    .clr       (state != SHIFT),
    .half_tick (half_tick)
  );

  // COPI moves on the same edge SCLK falls, so the peripheral sees stable data at the rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      shreg         <= '0;
      ph_cnt        <= '0;
      bit_cnt       <= '0;
      bus.spi_ncs   <= 1'b1;
      bus.spi_sclk  <= 1'b0;
      bus.spi_copi  <= 1'b0;
      bus.cmd_ready <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state         <= SETUP;
            shreg         <= frame_next;
            ph_cnt        <= '0;
            bit_cnt       <= '0;
            bus.spi_ncs   <= 1'b0;
            bus.spi_copi  <= frame_next[FRAME_LEN-1];
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
          end else begin
            bus.cmd_ready <= 1'b1;
          end
        end
        SETUP: begin
          if (ph_cnt == PH_W'(CS_SETUP - 1)) begin
            state  <= SHIFT;
            ph_cnt <= '0;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (half_tick) begin
            if (!bus.spi_sclk) begin
              bus.spi_sclk <= 1'b1;
            end else begin
              bus.spi_sclk <= 1'b0;
              if (bit_cnt == BIT_W'(FRAME_LEN - 1)) begin
                state <= HOLD;
              end else begin
                bit_cnt      <= bit_cnt + 1'b1;
                shreg        <= shreg << 1;
                bus.spi_copi <= shreg[FRAME_LEN-2];
              end
            end
          end
        end
        HOLD: begin
          if (ph_cnt == PH_W'(CS_HOLD - 1)) begin
            state        <= GAP;
            ph_cnt       <= '0;
            bus.spi_ncs  <= 1'b1;
            bus.spi_copi <= 1'b0;
            bus.done     <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        GAP: begin
          if (ph_cnt == PH_W'(CS_GAP - 1)) begin
            state         <= IDLE;
            ph_cnt        <= '0;
            bus.busy      <= 1'b0;
            bus.cmd_ready <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_ctrl_writer.sv
// Directed bench for spi_ctrl_writer: default instance plus a CLK_DIV=1 instance,
// with a bus-side decoder standing in for the peripheral register block.
module tb_spi_ctrl_writer;
  import spi_pkg::*;

  typedef struct {
    bit          sel;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_frame;
    int          exp_rise;
    int          exp_low;
    int          exp_done;
    int          exp_ready;
    int          inject;
  } vec_t;

  typedef struct {
    bit          started;
    logic [15:0] frame;
    int          bits;
    int          rise_k;
    int          low_n;
    int          done_k;
    int          done_n;
    int          ready_k;
    int          ncs_at1;
    int          ready_at1;
    int          inj_ready;
  } meas_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       drv_valid = 1'b0;
  logic [6:0] drv_addr = '0;
  logic [7:0] drv_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  spi_ctrl_writer_if #(.ADDR_W(7), .DATA_W(8)) a_if ();
  spi_ctrl_writer_if #(.ADDR_W(7), .DATA_W(8)) b_if ();

  assign a_if.cmd_valid = drv_valid && !sel;
  assign a_if.cmd_addr  = drv_addr;
  assign a_if.cmd_data  = drv_data;
  assign b_if.cmd_valid = drv_valid && sel;
  assign b_if.cmd_addr  = drv_addr;
  assign b_if.cmd_data  = drv_data;

  spi_ctrl_writer dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  spi_ctrl_writer #(
    .CLK_DIV(1), .ADDR_W(7), .DATA_W(8), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  always #5 clk = ~clk;

  logic m_ncs, m_sclk, m_copi, m_ready, m_done;
  assign m_ncs   = sel ? b_if.spi_ncs   : a_if.spi_ncs;
  assign m_sclk  = sel ? b_if.spi_sclk  : a_if.spi_sclk;
  assign m_copi  = sel ? b_if.spi_copi  : a_if.spi_copi;
  assign m_ready = sel ? b_if.cmd_ready : a_if.cmd_ready;
  assign m_done  = sel ? b_if.done      : a_if.done;

  // Peripheral model: shift on SCLK rise, commit a full write frame when nCS rises.
  logic [FRAME_W-1:0] mon_shreg = '0;
  logic [FRAME_W-1:0] mon_frame = '0;
  int                 mon_bits = 0;
  int                 mon_bits_done = 0;
  logic [7:0]         periph_regs [128];
  logic [7:0]         exp_regs [128];

  always @(negedge m_ncs) begin
    mon_shreg = '0;
    mon_bits  = 0;
  end

  always @(posedge m_sclk) begin
    if (!m_ncs) begin
      mon_shreg = {mon_shreg[FRAME_W-2:0], m_copi};
      mon_bits++;
    end
  end

  always @(posedge m_ncs) begin
    mon_frame     = mon_shreg;
    mon_bits_done = mon_bits;
    if (mon_bits == FRAME_W && mon_shreg[FRAME_W-1])
      periph_regs[mon_shreg[14:8]] = mon_shreg[7:0];
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one command and measures every event offset from the accept edge T0.
  task automatic applyStimulus(input vec_t v, output meas_t m);
    int waitc;
    m = '{default: 0};
    sel = v.sel;
    waitc = 0;
    @(negedge clk);
    while (!m_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!m_ready) return;
    m.started = 1'b1;
    drv_addr  = v.addr;
    drv_data  = v.data;
    drv_valid = 1'b1;
    @(posedge clk);
    #1 drv_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1) begin
        m.ncs_at1   = int'(m_ncs);
        m.ready_at1 = int'(m_ready);
      end
      if (!m_ncs) m.low_n++;
      if (m_sclk && m.rise_k == 0) m.rise_k = k;
      if (m_done) begin
        m.done_n++;
        if (m.done_k == 0) m.done_k = k;
      end
      if (v.inject != 0) begin
        if (k >= v.inject && k < v.inject + 3) begin
          if (m_ready) m.inj_ready++;
          drv_valid = 1'b1;
          drv_addr  = 7'h7F;
          drv_data  = 8'hFF;
        end else begin
          drv_valid = 1'b0;
        end
      end
      if (m_ready) begin
        m.ready_k = k;
        break;
      end
    end
    drv_valid = 1'b0;
    m.frame = mon_frame;
    m.bits  = mon_bits_done;
  endtask

  task automatic checkVector(input string tag, input vec_t v, input meas_t m);
    checkOutput({tag, "_started"}, int'(m.started), 1);
    checkOutput({tag, "_frame"},   int'(m.frame), int'(v.exp_frame));
    checkOutput({tag, "_bits"},    m.bits, 16);
    checkOutput({tag, "_ncs_t1"},  m.ncs_at1, 0);
    checkOutput({tag, "_rdy_t1"},  m.ready_at1, 0);
    checkOutput({tag, "_rise1"},   m.rise_k, v.exp_rise);
    checkOutput({tag, "_ncs_low"}, m.low_n, v.exp_low);
    checkOutput({tag, "_done_at"}, m.done_k, v.exp_done);
    checkOutput({tag, "_done_n"},  m.done_n, 1);
    checkOutput({tag, "_rdy_at"},  m.ready_k, v.exp_ready);
    if (v.inject != 0) checkOutput({tag, "_inj_rdy"}, m.inj_ready, 0);
  endtask

  vec_t  vecs [6];
  vec_t  v;
  meas_t m;

  initial begin
    logic [15:0] frame1;
    logic [15:0] frame2;
    int          accept2_k;
    int          high_n;
    int          rises;
    int          done_seen;
    int          diffs;
    bit          got1;
    bit          low2;
    bit          prev_sclk;

    for (int i = 0; i < 128; i++) periph_regs[i] = 8'h00;

    vecs[0] = '{1'b0, 7'h00, 8'hF0, 16'h80F0, 5, 68, 69, 71, 0};
    vecs[1] = '{1'b0, 7'h55, 8'h3C, 16'hD53C, 5, 68, 69, 71, 0};
    vecs[2] = '{1'b0, 7'h10, 8'h0F, 16'h900F, 5, 68, 69, 71, 20};
    vecs[3] = '{1'b1, 7'h00, 8'hF0, 16'h80F0, 3, 34, 35, 36, 0};
    vecs[4] = '{1'b1, 7'h2A, 8'hC3, 16'hAAC3, 3, 34, 35, 36, 0};
    vecs[5] = '{1'b0, 7'h7F, 8'h00, 16'hFF00, 5, 68, 69, 71, 0};

    repeat (3) @(negedge clk);
    checkOutput("rst_ncs",   int'(a_if.spi_ncs), 1);
    checkOutput("rst_sclk",  int'(a_if.spi_sclk), 0);
    checkOutput("rst_copi",  int'(a_if.spi_copi), 0);
    checkOutput("rst_ready", int'(a_if.cmd_ready), 0);
    checkOutput("rst_busy",  int'(a_if.busy), 0);
    checkOutput("rst_done",  int'(a_if.done), 0);
    checkOutput("rst_ncs_b", int'(b_if.spi_ncs), 1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_rise",   int'(a_if.cmd_ready), 1);
    checkOutput("ready_rise_b", int'(b_if.cmd_ready), 1);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i], m);
      checkVector($sformatf("v%0d", i), vecs[i], m);
    end

    // Back-to-back: valid held high across GAP, second command swapped in after T0.
    sel = 1'b0;
    frame1 = '0; frame2 = '0; accept2_k = 0; high_n = 0; got1 = 0; low2 = 0;
    @(negedge clk);
    drv_addr = 7'h01; drv_data = 8'hAA; drv_valid = 1'b1;
    @(posedge clk);
    #1 drv_addr = 7'h02; drv_data = 8'h55;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (!got1 && m_ncs) begin
        got1   = 1'b1;
        frame1 = mon_frame;
      end
      if (got1 && !low2) begin
        if (m_ncs) high_n++;
        else       low2 = 1'b1;
      end
      if (m_ready && accept2_k == 0) begin
        accept2_k = k;
        @(posedge clk);
        #1 drv_valid = 1'b0;
      end else if (m_ready && accept2_k != 0) begin
        break;
      end
    end
    drv_valid = 1'b0;
    frame2 = mon_frame;
    checkOutput("b2b_frame1", int'(frame1), 16'h81AA);
    checkOutput("b2b_accept2", accept2_k, 71);
    checkOutput("b2b_ncs_high", high_n, 3);
    checkOutput("b2b_frame2", int'(frame2), 16'h8255);

    // Reset asserted on the 8th SCLK rise of a frame.
    sel = 1'b0;
    rises = 0; done_seen = 0; prev_sclk = 1'b0;
    @(negedge clk);
    while (!m_ready) @(negedge clk);
    drv_addr = 7'h33; drv_data = 8'h99; drv_valid = 1'b1;
    @(posedge clk);
    #1 drv_valid = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (m_sclk && !prev_sclk) rises++;
      prev_sclk = m_sclk;
      if (m_done) done_seen++;
      if (rises == 8) break;
    end
    checkOutput("rst8_rises", rises, 8);
    checkOutput("rst8_copi_pre", int'(m_copi), 1);
    rst = 1'b1;
    #1;
    checkOutput("rst8_ncs",   int'(a_if.spi_ncs), 1);
    checkOutput("rst8_sclk",  int'(a_if.spi_sclk), 0);
    checkOutput("rst8_copi",  int'(a_if.spi_copi), 0);
    checkOutput("rst8_busy",  int'(a_if.busy), 0);
    checkOutput("rst8_ready", int'(a_if.cmd_ready), 0);
    repeat (2) begin
      @(negedge clk);
      if (m_done) done_seen++;
    end
    rst = 1'b0;
    checkOutput("rst8_no_done", done_seen, 0);
    checkOutput("rst8_partial", mon_bits_done, 8);
    checkOutput("rst8_no_write", int'(periph_regs[7'h33]), 0);
    v = '{1'b0, 7'h33, 8'h99, 16'hB399, 5, 68, 69, 71, 0};
    applyStimulus(v, m);
    checkVector("post_rst", v, m);
    checkOutput("post_rst_reg", int'(periph_regs[7'h33]), 8'h99);

    // Loopback: write 0xA5 to register 4, nothing else may change.
    for (int i = 0; i < 128; i++) exp_regs[i] = periph_regs[i];
    exp_regs[4] = 8'hA5;
    v = '{1'b0, 7'h04, 8'hA5, 16'h84A5, 5, 68, 69, 71, 0};
    applyStimulus(v, m);
    checkVector("loop", v, m);
    checkOutput("loop_reg4", int'(periph_regs[4]), 8'hA5);
    diffs = 0;
    for (int i = 0; i < 128; i++)
      if (periph_regs[i] !== exp_regs[i]) diffs++;
    checkOutput("loop_others", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
